// File: rtl/resp_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resp_bridge_pkg
// Description : Shared constants and helpers for the response block bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package resp_bridge_pkg;

    // Widest slave vector the helper functions accept.
    localparam int c_MAX_PORTS = 256;

    function automatic int padded_ports(input int n);
        return 1 << $clog2(n);
    endfunction

    function automatic logic is_onehot(input logic [c_MAX_PORTS-1:0] v);
        return ($countones(v) == 1);
    endfunction

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic int prio_index(input logic [c_MAX_PORTS-1:0] v);
        int idx;
        idx = 0;
        for (int i = c_MAX_PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage : resp_bridge_pkg
`default_nettype wire

// File: rtl/resp_bridge_ot_counter.sv
`default_nettype none
// ============================================================================
// Module      : resp_bridge_ot_counter
// Description : Saturating up/down in-flight counter with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_bridge_ot_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] c_MAX = CW'(MAX_COUNT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !dec && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign full  = (r_count == c_MAX);
    assign empty = (r_count == '0);

endmodule : resp_bridge_ot_counter
`default_nettype wire

// File: rtl/resp_block_bridge_ot.sv
`default_nettype none
// ============================================================================
// Module      : resp_block_bridge_ot
// Description : Request router with outstanding limit and priority response merge.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_block_bridge_ot
    import resp_bridge_pkg::*;
#(
    parameter int ID              = 1,
    parameter int ID_WIDTH        = 17,
    parameter int N_SLAVE         = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = DATA_WIDTH / 8,
    parameter int AUX_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_PIPE       = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_SLAVE-1:0]                       data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                    data_r_rdata_i [N_SLAVE],
    input  logic [TAG_WIDTH-1:0]                     data_r_rtag_i  [N_SLAVE],
    input  logic [N_SLAVE-1:0]                       data_r_opc_i,
    input  logic [AUX_WIDTH-1:0]                     data_r_aux_i   [N_SLAVE],
    output logic                                     data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                    data_r_rdata_o,
    output logic [TAG_WIDTH-1:0]                     data_r_rtag_o,
    output logic                                     data_r_opc_o,
    output logic [AUX_WIDTH-1:0]                     data_r_aux_o,
    input  logic                                     data_req_i,
    input  logic [N_SLAVE-1:0]                       destination_i,
    output logic                                     data_gnt_o,
    output logic [N_SLAVE-1:0]                       data_req_o,
    input  logic [N_SLAVE-1:0]                       data_gnt_i,
    output logic [ID_WIDTH-1:0]                      data_ID_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     err_o
);

    localparam int c_PAD = padded_ports(N_SLAVE);
    localparam int c_IW  = (c_PAD > 1) ? $clog2(c_PAD) : 1;
    localparam int c_CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ID_WIDTH-1:0] c_ID = ID_WIDTH'(ID);

    logic                  w_dest_ok;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_req_ok;
    logic                  w_accept;
    logic                  w_retire;
    logic                  w_any;
    logic                  w_multi;
    logic [c_IW-1:0]       w_sel;
    logic [c_PAD-1:0]      w_valid_pad;
    logic [c_PAD-1:0]      w_opc_pad;
    logic [DATA_WIDTH-1:0] w_rdata_pad [c_PAD];
    logic [TAG_WIDTH-1:0]  w_rtag_pad  [c_PAD];
    logic [AUX_WIDTH-1:0]  w_aux_pad   [c_PAD];
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic [TAG_WIDTH-1:0]  w_sel_rtag;
    logic                  w_sel_opc;
    logic [AUX_WIDTH-1:0]  w_sel_aux;
    logic [c_CW-1:0]       w_count;
    logic                  r_err;

    // Request side: forward only a legal one-hot destination while credit remains.
    assign w_dest_ok  = is_onehot(c_MAX_PORTS'(destination_i));
    assign w_req_ok   = data_req_i & w_dest_ok & ~w_full;
    assign data_req_o = w_req_ok ? destination_i : '0;
    assign data_gnt_o = w_req_ok & (|(data_gnt_i & destination_i));
    assign w_accept   = data_req_i & data_gnt_o;
    assign w_retire   = data_r_valid_o;

    for (genvar i = 0; i < c_PAD; i++) begin : g_pad
        if (i < N_SLAVE) begin : g_real
            assign w_valid_pad[i] = data_r_valid_i[i];
            assign w_opc_pad[i]   = data_r_opc_i[i];
            assign w_rdata_pad[i] = data_r_rdata_i[i];
            assign w_rtag_pad[i]  = data_r_rtag_i[i];
            assign w_aux_pad[i]   = data_r_aux_i[i];
        end else begin : g_zero
            assign w_valid_pad[i] = 1'b0;
            assign w_opc_pad[i]   = 1'b0;
            assign w_rdata_pad[i] = '0;
            assign w_rtag_pad[i]  = '0;
            assign w_aux_pad[i]   = '0;
        end
    end

    assign w_any       = |w_valid_pad;
    assign w_multi     = ($countones(w_valid_pad) > 1);
    assign w_sel       = c_IW'(prio_index(c_MAX_PORTS'(w_valid_pad)));
    assign w_sel_rdata = w_any ? w_rdata_pad[w_sel] : '0;
    assign w_sel_rtag  = w_any ? w_rtag_pad[w_sel]  : '0;
    assign w_sel_opc   = w_any & w_opc_pad[w_sel];
    assign w_sel_aux   = w_any ? w_aux_pad[w_sel]   : '0;

    if (RESP_PIPE == 1) begin : g_pipe
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_rdata;
        logic [TAG_WIDTH-1:0]  r_rtag;
        logic                  r_opc;
        logic [AUX_WIDTH-1:0]  r_aux;

        // Payload holds its last value when no slave responds.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_rdata <= '0;
                r_rtag  <= '0;
                r_opc   <= 1'b0;
                r_aux   <= '0;
            end else begin
                r_valid <= w_any;
                if (w_any) begin
                    r_rdata <= w_sel_rdata;
                    r_rtag  <= w_sel_rtag;
                    r_opc   <= w_sel_opc;
                    r_aux   <= w_sel_aux;
                end
            end
        end

        assign data_r_valid_o = r_valid;
        assign data_r_rdata_o = r_rdata;
        assign data_r_rtag_o  = r_rtag;
        assign data_r_opc_o   = r_opc;
        assign data_r_aux_o   = r_aux;
    end else begin : g_comb
        assign data_r_valid_o = w_any;
        assign data_r_rdata_o = w_sel_rdata;
        assign data_r_rtag_o  = w_sel_rtag;
        assign data_r_opc_o   = w_sel_opc;
        assign data_r_aux_o   = w_sel_aux;
    end

    resp_bridge_ot_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CW        (c_CW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_accept),
        .dec   (w_retire),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_multi || (w_retire && w_empty) || (data_req_i && !w_dest_ok)) begin
            r_err <= 1'b1;
        end
    end

    assign outstanding_o = w_count;
    assign err_o         = r_err;
    assign data_ID_o     = c_ID;

endmodule : resp_block_bridge_ot
`default_nettype wire

// File: tb/tb_resp_block_bridge_ot.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_block_bridge_ot
// Description : Directed bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_block_bridge_ot;

    localparam int NS  = 5;
    localparam int MO  = 2;
    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int AW  = 8;
    localparam int IDW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] valid_i, opc_i, dest_i, gnt_i;
    logic [DW-1:0] rdata_i [NS];
    logic [TW-1:0] rtag_i  [NS];
    logic [AW-1:0] aux_i   [NS];
    logic          req_i;
    logic          valid_o, opc_o, gnt_o, err_o;
    logic [DW-1:0] rdata_o;
    logic [TW-1:0] rtag_o;
    logic [AW-1:0] aux_o;
    logic [NS-1:0] req_o;
    logic [IDW-1:0] id_o;
    logic [1:0]    out_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference state
    int            m_out;
    bit            m_err, m_vld;
    logic [DW-1:0] m_rdata;
    logic [TW-1:0] m_rtag;
    logic          m_opc;
    logic [AW-1:0] m_aux;

    always #5 clk = ~clk;

    resp_block_bridge_ot #(
        .ID(1), .ID_WIDTH(IDW), .N_SLAVE(NS), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
        .AUX_WIDTH(AW), .MAX_OUTSTANDING(MO), .RESP_PIPE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_r_valid_i(valid_i), .data_r_rdata_i(rdata_i), .data_r_rtag_i(rtag_i),
        .data_r_opc_i(opc_i), .data_r_aux_i(aux_i),
        .data_r_valid_o(valid_o), .data_r_rdata_o(rdata_o), .data_r_rtag_o(rtag_o),
        .data_r_opc_o(opc_o), .data_r_aux_o(aux_o),
        .data_req_i(req_i), .destination_i(dest_i), .data_gnt_o(gnt_o),
        .data_req_o(req_o), .data_gnt_i(gnt_i),
        .data_ID_o(id_o), .outstanding_o(out_o), .err_o(err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req_ok();
        return req_i && ($countones(dest_i) == 1) && (m_out < MO);
    endfunction

    // Model advances on each edge from the rules, not from DUT state.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_out = 0; m_err = 0; m_vld = 0;
            m_rdata = '0; m_rtag = '0; m_opc = 0; m_aux = '0;
        end else begin
            bit accept, retire;
            int sel;
            accept = m_req_ok() && ((gnt_i & dest_i) != '0);
            retire = m_vld;
            if ($countones(valid_i) > 1 || (retire && m_out == 0) ||
                (req_i && $countones(dest_i) != 1))
                m_err = 1;
            if (accept && !retire) m_out = m_out + 1;
            else if (retire && !accept && m_out > 0) m_out = m_out - 1;
            m_vld = (valid_i != '0);
            if (m_vld) begin
                sel = 0;
                for (int i = NS - 1; i >= 0; i--) if (valid_i[i]) sel = i;
                m_rdata = rdata_i[sel]; m_rtag = rtag_i[sel];
                m_opc = opc_i[sel]; m_aux = aux_i[sel];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_o", req_o, m_req_ok() ? dest_i : '0);
            check("gnt_o", gnt_o, m_req_ok() && ((gnt_i & dest_i) != '0));
            check("outstanding", out_o, m_out);
            check("err", err_o, m_err);
            check("valid_o", valid_o, m_vld);
            check("payload", {rdata_o, rtag_o, opc_o, aux_o}, {m_rdata, m_rtag, m_opc, m_aux});
            check("id", id_o, 17'd1);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_i = 0; dest_i = '0; gnt_i = '0; valid_i = '0;
        opc_i = 5'b01010;
        for (int i = 0; i < NS; i++) begin
            rdata_i[i] = 32'hA0A0_0000 | i;
            rtag_i[i]  = TW'(i + 1);
            aux_i[i]   = AW'(8'h10 + i);
        end
        repeat (3) @(posedge clk);
        #1; chk_en = 1'b1;
        at_neg();
        check("rst_outstanding", out_o, 0);
        check("rst_err", err_o, 0);
        check("rst_valid", valid_o, 0);

        // Fill to the limit on slave 3
        step(); rst_n = 1'b1; req_i = 1; dest_i = 5'b01000; gnt_i = 5'b01000;
        step();
        step();
        at_neg();
        check("full_req_o", req_o, 0);
        check("full_gnt_o", gnt_o, 0);
        check("full_outstanding", out_o, 2);

        // Registered response from slave 4
        step(); req_i = 0; dest_i = '0; gnt_i = '0; valid_i = 5'b10000; rdata_i[4] = 32'hDEADBEEF;
        at_neg();
        check("pipe_t_valid", valid_o, 0);
        step(); valid_i = '0;
        at_neg();
        check("pipe_t1_valid", valid_o, 1);
        check("pipe_t1_rdata", rdata_o, 32'hDEADBEEF);
        step();
        at_neg();
        check("pipe_t2_valid", valid_o, 0);
        check("pipe_hold_rdata", rdata_o, 32'hDEADBEEF);
        check("after_retire", out_o, 1);

        // Accept and retire in the same cycle
        step(); valid_i = 5'b00001;
        step(); valid_i = '0; req_i = 1; dest_i = 5'b00001; gnt_i = 5'b00001;
        at_neg();
        check("both_gnt", gnt_o, 1);
        step(); req_i = 0; dest_i = '0; gnt_i = '0;
        at_neg();
        check("both_outstanding", out_o, 1);
        check("both_err", err_o, 0);

        // Slave withholds grant
        step(); req_i = 1; dest_i = 5'b00100; gnt_i = '0;
        at_neg();
        check("nognt_req_o", req_o, 5'b00100);
        check("nognt_gnt_o", gnt_o, 0);
        step(); req_i = 0; dest_i = '0;

        // Two simultaneous responses
        step(); valid_i = 5'b00110;
        step(); valid_i = '0;
        at_neg();
        check("multi_rdata", rdata_o, 32'hA0A0_0001);
        check("multi_err", err_o, 1);
        repeat (3) step();
        at_neg();
        check("multi_err_held", err_o, 1);
        do_reset();
        at_neg();
        check("err_cleared", err_o, 0);

        // Non-one-hot destination
        step(); req_i = 1; dest_i = 5'b00101; gnt_i = 5'b11111;
        at_neg();
        check("bad_dest_req_o", req_o, 0);
        check("bad_dest_gnt_o", gnt_o, 0);
        step(); req_i = 0; dest_i = '0; gnt_i = '0;
        at_neg();
        check("bad_dest_err", err_o, 1);
        do_reset();

        // Retire with nothing outstanding
        step(); valid_i = 5'b01000;
        step(); valid_i = '0;
        step();
        at_neg();
        check("underflow_err", err_o, 1);
        check("underflow_count", out_o, 0);
        do_reset();

        // Reset mid-transaction
        step(); req_i = 1; dest_i = 5'b00010; gnt_i = 5'b00010;
        step();
        step(); req_i = 0; dest_i = '0; gnt_i = '0; valid_i = 5'b00011;
        step(); valid_i = '0;
        at_neg();
        check("pre_rst_valid", valid_o, 1);
        check("pre_rst_outstanding", out_o, 2);
        check("pre_rst_err", err_o, 1);
        rst_n = 1'b0;
        step();
        at_neg();
        check("mid_rst_outstanding", out_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_rdata", rdata_o, 0);
        step(); rst_n = 1'b1;
        repeat (2) step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_resp_block_bridge_ot
`default_nettype wire

// File: doc/resp_block_bridge_ot.md
RESP_BLOCK_BRIDGE_OT -- requirements
Module: resp_block_bridge_ot

Interface
REQ-001 SHALL have parameter ID, default 1: constant driven on data_ID_o.
REQ-002 SHALL have parameter ID_WIDTH, default 17: width of data_ID_o.
REQ-003 SHALL have parameter N_SLAVE, default 16: slave ports; any value >= 1, power of 2 not required.
REQ-004 SHALL have parameters DATA_WIDTH=32, TAG_WIDTH=DATA_WIDTH/8, AUX_WIDTH=8: payload widths.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..255: in-flight request limit.
REQ-006 SHALL have parameter RESP_PIPE, default 1, range 0..1: registered response output when 1.
REQ-007 SHALL have clk  in  1  sole clock, rising edge.
REQ-008 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-009 SHALL have data_r_valid_i  in  N_SLAVE  per-slave response valid.
REQ-010 SHALL have data_r_rdata_i / data_r_rtag_i / data_r_opc_i / data_r_aux_i  in  N_SLAVE x (DATA_WIDTH / TAG_WIDTH / 1 / AUX_WIDTH)  per-slave response payload.
REQ-011 SHALL have data_r_valid_o  out  1  merged response valid.
REQ-012 SHALL have data_r_rdata_o / data_r_rtag_o / data_r_opc_o / data_r_aux_o  out  DATA_WIDTH / TAG_WIDTH / 1 / AUX_WIDTH  merged response payload.
REQ-013 SHALL have data_req_i  in  1, destination_i  in  N_SLAVE (one-hot), data_gnt_o  out  1: master request side.
REQ-014 SHALL have data_req_o  out  N_SLAVE, data_gnt_i  in  N_SLAVE: slave request side.
REQ-015 SHALL have data_ID_o  out  ID_WIDTH  constant ID.
REQ-016 SHALL have outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
REQ-017 SHALL have err_o  out  1  sticky protocol-error flag.

Function
REQ-018 dest_ok SHALL be true iff destination_i has exactly one bit set; full SHALL be true iff outstanding == MAX_OUTSTANDING.
REQ-019 data_req_o SHALL equal destination_i when data_req_i & dest_ok & !full, else all zero; combinational, zero latency.
REQ-020 data_gnt_o SHALL equal the data_gnt_i bit selected by destination_i, gated by data_req_i & dest_ok & !full.
REQ-021 Accept event: data_req_i & data_gnt_o; retire event: data_r_valid_o.
REQ-022 outstanding SHALL be +1 on accept only, -1 on retire only, unchanged on both or neither; it never wraps.
REQ-023 Response select: lowest-index asserted data_r_valid_i wins; payload taken from that slave; slaves beyond N_SLAVE padded as never-valid.
REQ-024 RESP_PIPE=0: outputs combinational from selected slave, latency 0; payload 0 when no valid.
REQ-025 RESP_PIPE=1: data_r_valid_o registered, latency 1 cycle; payload registers load only when any input valid, hold otherwise.
REQ-026 err_o SHALL set one cycle after any of: >1 data_r_valid_i bits in same cycle; retire with outstanding==0; data_req_i with !dest_ok; remains set until reset.
REQ-027 Retire with outstanding==0 SHALL leave outstanding at 0.
REQ-028 data_ID_o SHALL equal ID[ID_WIDTH-1:0] at all times.

Reset
REQ-029 On clk edge with rst_n=0: outstanding=0, err_o=0, pipeline valid=0, pipeline payload=0; reset mid-transaction discards in-flight count and any registered response.
REQ-030 Request-side outputs SHALL follow REQ-019/020 with outstanding=0 during reset.

Structure
REQ-031 Shared package resp_bridge_pkg SHALL hold padded-port constant (2**$clog2(N_SLAVE)) and one-hot-check/priority-select functions.
REQ-032 Single sub-module resp_bridge_ot_counter SHALL implement the saturating up/down outstanding counter with full flag.

Verification
REQ-033 N_SLAVE=5, MAX_OUTSTANDING=2: two grants to slave 3, third request -> data_req_o=0, data_gnt_o=0, outstanding_o=2.
REQ-034 Same cycle accept and retire at outstanding=1 -> outstanding_o stays 1, err_o=0.
REQ-035 RESP_PIPE=1: slave 4 valid, rdata=0xDEADBEEF at cycle t -> data_r_valid_o=1, rdata=0xDEADBEEF at t+1 only.
REQ-036 data_r_valid_i=5'b00110 -> slave 1 payload output, err_o=1 next cycle, held until rst_n=0.
REQ-037 destination_i=5'b00101 with data_req_i=1 -> data_req_o=0, data_gnt_o=0, err_o=1.
REQ-038 Reset asserted with outstanding=2 and pipe valid -> next cycle outstanding_o=0, data_r_valid_o=0, err_o=0.
